// File: rtl/shift_unit.sv
// Multi-cycle variable shifter (SLL/SRL/SRA, optional ROTR) shifting at most STEP bits
// per cycle, with valid/ready handshakes on both sides. Rotate enabled by SHIFT_UNIT_ROTATE_EN.
module shift_unit #(
  parameter  int WIDTH   = 32,
  parameter  int STEP    = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int RW = SHAMT_W + 1;
  localparam logic [RW-1:0] STEP_R  = RW'(STEP);
  localparam logic [RW-1:0] WIDTH_R = RW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  acc_reg, acc_next;
  logic [RW-1:0]     rem_reg, rem_next;
  logic [1:0]        op_reg, op_next;
  logic              sign_reg, sign_next;
  logic [RW-1:0]     k;
  logic [WIDTH-1:0]  shifted;

  assign k = (rem_reg > STEP_R) ? STEP_R : rem_reg;

  // One step of the selected shift; the sign bit is carried in sign_reg for SRA fill.
  always_comb begin
    shifted = acc_reg << k;
    case (op_reg)
      2'b01:   shifted = acc_reg >> k;
      2'b10:   shifted = WIDTH'($signed({sign_reg, acc_reg}) >>> k);
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b11:   shifted = (acc_reg >> k) | (acc_reg << (WIDTH_R - k));
`endif
      default: shifted = acc_reg << k;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    op_next    = op_reg;
    sign_next  = sign_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          acc_next   = in_data;
          rem_next   = {1'b0, in_shamt};
          op_next    = in_op;
          sign_next  = in_data[WIDTH-1];
          state_next = (in_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_next = shifted;
        rem_next = rem_reg - k;
        if (rem_reg <= STEP_R) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      rem_reg   <= '0;
      op_reg    <= '0;
      sign_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      op_reg    <= op_next;
      sign_reg  <= sign_next;
    end
  end

  // Handshake signals depend on state alone, never on in_valid/out_ready.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_data  = acc_reg;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: arithmetic reference model checked every cycle, plus
// literal expectations for result values and latencies.
module tb_shift_unit;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the operation definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b01: r = d >> s;
      2'b10: r = $signed(d) >>> s;
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b11: r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
`endif
      default: r = d << s;
    endcase
    return r;
  endfunction

  // Model: 0 idle, 1 working, 2 result held. Latency = 1 + ceil(shamt/STEP).
  int          m_ph = 0;
  int          m_left = 0;
  logic [31:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_left <= 0; m_res <= '0;
    end else begin
      case (m_ph)
        0: if (in_valid) begin
             m_res  <= ref_shift(in_data, int'(in_shamt), in_op);
             m_left <= (int'(in_shamt) + STEP - 1) / STEP;
             m_ph   <= (in_shamt == 0) ? 2 : 1;
           end
        1: begin
             if (m_left == 1) m_ph <= 2;
             m_left <= m_left - 1;
           end
        default: if (out_ready) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_ph == 0});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ph == 2});
    chk("busy", {31'b0, busy}, {31'b0, m_ph != 0});
    if (m_ph == 2) chk("out_data_model", out_data, m_res);
    if (!rst_n) chk("out_data_reset", out_data, 32'h0);
  end

  // Issue one request, wait for the result, optionally hold back-pressure, then take it.
  task automatic run(input string name, input logic [31:0] d, input logic [4:0] s,
                     input logic [1:0] op, input logic [31:0] exp, input int exp_lat,
                     input int hold);
    int lat;
    logic [31:0] first;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = 32'hA5A5_5A5A; in_shamt = 5'd3; in_op = 2'b01;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_data"}, out_data, exp);
    first = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      chk({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({name, "_hold_data"}, out_data, first);
      chk({name, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({name, "_hs_in_ready"}, {31'b0, in_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_after_hs_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({name, "_after_hs_valid"}, {31'b0, out_valid}, 32'd0);
    $display("txn %s: d=0x%08h shamt=%0d op=%0d -> 0x%08h lat=%0d", name, d, s, op, first, lat);
  endtask

  initial begin
    logic [31:0] rot_exp;
`ifdef SHIFT_UNIT_ROTATE_EN
    rot_exp = 32'h7812_3456;
`else
    rot_exp = 32'h3456_7800;
`endif
    repeat (2) @(negedge clk);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_out_data", out_data, 32'h0);
    rst_n = 1'b1;

    run("sll_branch", 32'h0000_0001, 5'd2,  2'b00, 32'h0000_0004, 2, 0);
    run("sra_31",     32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 9, 0);
    run("srl_31",     32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 9, 0);
    run("srl_0",      32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF, 1, 0);
    run("sll_hold",   32'h0000_00FF, 5'd8,  2'b00, 32'h0000_FF00, 3, 5);
    run("sra_pos",    32'h7000_0000, 5'd5,  2'b10, 32'h0380_0000, 3, 0);
    run("sra_neg",    32'hF000_0F00, 5'd6,  2'b10, 32'hFFC0_003C, 3, 0);
    run("rotr_8",     32'h1234_5678, 5'd8,  2'b11, rot_exp, 3, 0);

    // Reset two cycles into an SRA by 20.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h8000_0000; in_shamt = 5'd20; in_op = 2'b10;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_out_data", out_data, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    $display("txn reset_mid_sra: discarded, in_ready=%0d", in_ready);
    run("sll_after_rst", 32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002, 2, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
